// File: rtl/ex_hilo_ctrl_pkg.sv
// Funct codes, bus widths, FSM state type and the funct decode helper shared
// by the HI/LO sequencer and its register file.
package ex_hilo_ctrl_pkg;

    localparam int DATA_W  = 32;
    localparam int DDATA_W = 64;
    localparam int FUNCT_W = 6;

    localparam logic [FUNCT_W-1:0] FUNCT_MFHI  = 6'h10;
    localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'h11;
    localparam logic [FUNCT_W-1:0] FUNCT_MFLO  = 6'h12;
    localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'h13;
    localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'h18;
    localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'h19;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } hilo_state_e;

    typedef struct packed {
        logic is_mul;
        logic is_mt;
        logic is_mf;
    } funct_class_t;

    function automatic funct_class_t classify_funct(input logic [FUNCT_W-1:0] f);
        funct_class_t c;
        c.is_mul = (f == FUNCT_MULT) || (f == FUNCT_MULTU);
        c.is_mt  = (f == FUNCT_MTHI) || (f == FUNCT_MTLO);
        c.is_mf  = (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
        return c;
    endfunction

endpackage

// File: rtl/ex_hilo_ctrl_hilo_reg.sv
// Architectural HI/LO pair: one 64-bit product write port and separate
// 32-bit MTHI/MTLO write ports.
module hilo_reg
    import ex_hilo_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_mul_we,
    input  logic [DDATA_W-1:0] i_mul_wdata,
    input  logic               i_hi_we,
    input  logic [DATA_W-1:0]  i_hi_wdata,
    input  logic               i_lo_we,
    input  logic [DATA_W-1:0]  i_lo_wdata,
    output logic [DATA_W-1:0]  o_hi,
    output logic [DATA_W-1:0]  o_lo
);

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    // The controller never raises a product write together with an MT write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (i_mul_we) begin
            r_hi <= i_mul_wdata[DDATA_W-1:DATA_W];
            r_lo <= i_mul_wdata[DATA_W-1:0];
        end else begin
            if (i_hi_we) r_hi <= i_hi_wdata;
            if (i_lo_we) r_lo <= i_lo_wdata;
        end
    end

    assign o_hi = r_hi;
    assign o_lo = r_lo;

endmodule

// File: rtl/ex_hilo_ctrl.sv
// EX-stage HI/LO sequencer: issues multiplies, stalls the pipe until the
// product is captured, and services MTHI/MTLO/MFHI/MFLO.
module ex_hilo_ctrl
    import ex_hilo_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 1,
    parameter int CNT_W       = 4
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [DATA_W-1:0]  operand_1,
    input  logic [DATA_W-1:0]  operand_2,
    input  logic               flush,
    output logic               mul_en,
    output logic               mul_signed,
    output logic [DATA_W-1:0]  mul_op1,
    output logic [DATA_W-1:0]  mul_op2,
    input  logic               mul_done,
    input  logic [DDATA_W-1:0] mul_result,
    output logic               stall_req,
    output logic [DATA_W-1:0]  hilo_rdata,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LATENCY - 1);

    hilo_state_e       r_state;
    hilo_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic              r_signed;
    funct_class_t      w_cls;
    logic              w_idle;
    logic              w_busy;
    logic              w_at_last;
    logic              w_issue;
    logic              w_capture;
    logic              w_mt_wr;

    assign w_cls     = classify_funct(funct);
    assign w_idle    = (r_state == ST_IDLE);
    assign w_busy    = (r_state == ST_BUSY);
    assign w_at_last = (r_cnt == CNT_LAST);
    assign w_issue   = w_idle & ex_valid & w_cls.is_mul & !flush;
    // flush suppresses the product write even on the capture cycle
    assign w_capture = w_busy & w_at_last & mul_done & !flush;
    assign w_mt_wr   = w_idle & ex_valid & w_cls.is_mt & !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (ex_valid && w_cls.is_mul) w_state_nxt = ST_BUSY;
                ST_BUSY: if (w_at_last && mul_done)    w_state_nxt = ST_IDLE;
                default:                               w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Operands are frozen at issue so the multiplier sees stable inputs all of BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
        end else if (w_issue) begin
            r_cnt    <= '0;
            r_op1    <= operand_1;
            r_op2    <= operand_2;
            r_signed <= (funct == FUNCT_MULT);
        end else if (w_busy && !w_at_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        mul_en     = w_busy;
        stall_req  = !flush & ((w_idle & ex_valid & w_cls.is_mul) |
                               (w_busy & !(w_at_last & mul_done)));
        hilo_rdata = '0;
        if (funct == FUNCT_MFHI)      hilo_rdata = hi;
        else if (funct == FUNCT_MFLO) hilo_rdata = lo;
    end

    assign mul_signed = r_signed;
    assign mul_op1    = r_op1;
    assign mul_op2    = r_op2;

    hilo_reg u_hilo_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mul_we    (w_capture),
        .i_mul_wdata (mul_result),
        .i_hi_we     (w_mt_wr & (funct == FUNCT_MTHI)),
        .i_hi_wdata  (operand_1),
        .i_lo_we     (w_mt_wr & (funct == FUNCT_MTLO)),
        .i_lo_wdata  (operand_1),
        .o_hi        (hi),
        .o_lo        (lo)
    );

endmodule
